// File: rtl/bnn_seq_pkg.sv
// rtl/bnn_seq_pkg.sv - FSM state encoding and width helpers for the folded BNN classifier.
package bnn_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        L1,
        L2,
        DONE
    } state_t;

    // Signed first-layer sum: feature magnitude, growth over FEAT_CNT terms, sign bit.
    function automatic int acc_width(input int feat_cnt, input int feat_bits);
        return feat_bits + $clog2(feat_cnt + 1) + 1;
    endfunction

    function automatic int sum_width(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bnn_l1_lane.sv
// rtl/bnn_l1_lane.sv - one hidden neuron: signed +/-feature sum followed by sign activation.
module bnn_l1_lane
    import bnn_seq_pkg::*;
#(
    parameter int FEAT_CNT  = 12,
    parameter int FEAT_BITS = 4
) (
    input  logic [FEAT_CNT*FEAT_BITS-1:0] features,
    input  logic [FEAT_CNT-1:0]           weights,
    output logic                          hidden_bit
);

    localparam int AW = acc_width(FEAT_CNT, FEAT_BITS);

    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] term;

    always_comb begin
        acc  = '0;
        term = '0;
        for (int i = 0; i < FEAT_CNT; i++) begin
            term = $signed({{(AW-FEAT_BITS){1'b0}}, features[i*FEAT_BITS +: FEAT_BITS]});
            if (weights[i]) begin
                acc = acc + term;
            end else begin
                acc = acc - term;
            end
        end
        // A zero sum activates the neuron.
        hidden_bit = ~acc[AW-1];
    end

endmodule

// File: rtl/bnn_seq_classifier.sv
// rtl/bnn_seq_classifier.sv - folded two-layer BNN classifier; BNN_SEQ_SCORE_EN exposes the winning popcount.
module bnn_seq_classifier
    import bnn_seq_pkg::*;
#(
    parameter int FEAT_CNT   = 12,
    parameter int FEAT_BITS  = 4,
    parameter int HIDDEN_CNT = 40,
    parameter int CLASS_CNT  = 6,
    parameter int PAR        = 4,
    parameter logic [HIDDEN_CNT*FEAT_CNT-1:0]  W1 = '1,
    parameter logic [CLASS_CNT*HIDDEN_CNT-1:0] W2 = '1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [FEAT_CNT*FEAT_BITS-1:0]     features,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [idx_width(CLASS_CNT)-1:0]   prediction
`ifdef BNN_SEQ_SCORE_EN
    ,
    output logic [sum_width(HIDDEN_CNT)-1:0]  score
`endif
);

    localparam int GROUPS = HIDDEN_CNT / PAR;
    localparam int GW     = idx_width(GROUPS);
    localparam int CW     = idx_width(CLASS_CNT);
    localparam int SW     = sum_width(HIDDEN_CNT);

    if ((PAR < 1) || (PAR > HIDDEN_CNT) || (HIDDEN_CNT % PAR != 0)) begin : g_bad_par
        $error("bnn_seq_classifier: HIDDEN_CNT must be a multiple of PAR, 1 <= PAR <= HIDDEN_CNT");
    end
    if (CLASS_CNT < 2) begin : g_bad_class
        $error("bnn_seq_classifier: CLASS_CNT must be at least 2");
    end

    state_t state, state_nxt;

    logic [FEAT_CNT*FEAT_BITS-1:0] feat_q;
    logic [HIDDEN_CNT-1:0]         hidden_q;
    logic [GW-1:0]                 g_q;
    logic [CW-1:0]                 c_q;
    logic [SW-1:0]                 best_q;
    logic [CW-1:0]                 best_idx_q;

    logic [PAR-1:0][FEAT_CNT-1:0]  lane_w;
    logic [PAR-1:0]                lane_bit;
    logic [HIDDEN_CNT-1:0]         w2_row;
    logic [SW-1:0]                 l2_sum;
    logic                          g_last;
    logic                          c_last;

    assign g_last = (g_q == GW'(GROUPS - 1));
    assign c_last = (c_q == CW'(CLASS_CNT - 1));

    // Constant-indexed mux trees keep weight selection free of variable part-selects.
    always_comb begin
        lane_w = '0;
        for (int gg = 0; gg < GROUPS; gg++) begin
            if (g_q == GW'(gg)) begin
                for (int p = 0; p < PAR; p++) begin
                    lane_w[p] = W1[(gg*PAR + p)*FEAT_CNT +: FEAT_CNT];
                end
            end
        end
    end

    for (genvar p = 0; p < PAR; p++) begin : g_lane
        bnn_l1_lane #(
            .FEAT_CNT (FEAT_CNT),
            .FEAT_BITS(FEAT_BITS)
        ) u_lane (
            .features  (feat_q),
            .weights   (lane_w[p]),
            .hidden_bit(lane_bit[p])
        );
    end

    always_comb begin
        w2_row = '0;
        for (int cc = 0; cc < CLASS_CNT; cc++) begin
            if (c_q == CW'(cc)) begin
                w2_row = W2[cc*HIDDEN_CNT +: HIDDEN_CNT];
            end
        end
        l2_sum = '0;
        for (int h = 0; h < HIDDEN_CNT; h++) begin
            l2_sum = l2_sum + SW'(~(hidden_q[h] ^ w2_row[h]));
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = L1;
            L1:      if (g_last)    state_nxt = L2;
            L2:      if (c_last)    state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == DONE);
    assign prediction = best_idx_q;
`ifdef BNN_SEQ_SCORE_EN
    assign score      = best_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            feat_q     <= '0;
            hidden_q   <= '0;
            g_q        <= '0;
            c_q        <= '0;
            best_q     <= '0;
            best_idx_q <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        feat_q <= features;
                        g_q    <= '0;
                    end
                end
                L1: begin
                    for (int gg = 0; gg < GROUPS; gg++) begin
                        if (g_q == GW'(gg)) begin
                            for (int p = 0; p < PAR; p++) begin
                                hidden_q[gg*PAR + p] <= lane_bit[p];
                            end
                        end
                    end
                    if (g_last) begin
                        c_q        <= '0;
                        best_q     <= '0;
                        best_idx_q <= '0;
                    end else begin
                        g_q <= g_q + GW'(1);
                    end
                end
                L2: begin
                    // Strict compare keeps the lowest class index on ties.
                    if ((c_q == '0) || (l2_sum > best_q)) begin
                        best_q     <= l2_sum;
                        best_idx_q <= c_q;
                    end
                    if (!c_last) begin
                        c_q <= c_q + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bnn_seq_classifier.sv
// tb/tb_bnn_seq_classifier.sv - four lockstep classifier instances with different weights checked against a model.
module tb_bnn_seq_classifier;

    localparam int FC = 2;
    localparam int FB = 4;
    localparam int HC = 4;
    localparam int P  = 2;
    localparam int CC = 3;
    localparam int ND = 4;

    // dut0: sign test, dut1: argmax, dut2: ties, dut3: mixed weights
    localparam logic [31:0] W1_ALL = {8'h27, 8'hFF, 8'hFF, 8'h00};
    localparam logic [47:0] W2_ALL = {12'h3B7, 12'h0FF, 12'h3F0, 12'h3F0};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] features = '0;

    logic [ND-1:0] in_ready_v;
    logic [ND-1:0] out_valid_v;
    logic [1:0]    pred_v [ND];
`ifdef BNN_SEQ_SCORE_EN
    logic [2:0]    score_v [ND];
`endif

    int checks = 0;
    int failures = 0;
    int q_pred[$];
    int q_score[$];
    int exp_pred_last [ND];
    int exp_score_last [ND];

    always #5 clk = ~clk;

    for (genvar k = 0; k < ND; k++) begin : g_dut
        bnn_seq_classifier #(
            .FEAT_CNT  (FC),
            .FEAT_BITS (FB),
            .HIDDEN_CNT(HC),
            .CLASS_CNT (CC),
            .PAR       (P),
            .W1        (W1_ALL[k*8 +: 8]),
            .W2        (W2_ALL[k*12 +: 12])
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (in_ready_v[k]),
            .features  (features),
            .out_valid (out_valid_v[k]),
            .out_ready (out_ready),
            .prediction(pred_v[k])
`ifdef BNN_SEQ_SCORE_EN
            ,
            .score     (score_v[k])
`endif
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void ref_model(input int k, input int f0, input int f1,
                                      output int pred, output int sc);
        logic [7:0]  w1;
        logic [11:0] w2;
        int          hb [HC];
        int          a;
        int          s;
        int          best;
        w1   = W1_ALL[k*8 +: 8];
        w2   = W2_ALL[k*12 +: 12];
        pred = 0;
        best = -1;
        for (int h = 0; h < HC; h++) begin
            a = (w1[h*2] ? f0 : -f0) + (w1[h*2+1] ? f1 : -f1);
            hb[h] = (a >= 0) ? 1 : 0;
        end
        for (int c = 0; c < CC; c++) begin
            s = 0;
            for (int h = 0; h < HC; h++) begin
                if (hb[h] == int'(w2[c*HC + h])) s++;
            end
            if (s > best) begin
                best = s;
                pred = c;
            end
        end
        sc = best;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int f0, input int f1);
        int pr;
        int sc;
        for (int k = 0; k < ND; k++) begin
            ref_model(k, f0, f1, pr, sc);
            q_pred.push_back(pr);
            q_score.push_back(sc);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (in_ready_v != '1 && n < 100) begin
            tick();
            n++;
        end
        chk("in_ready_wait", 32'(in_ready_v), 32'hF);
    endtask

    // Handshake happens at the edge inside; returns just after it, bus then scrambled.
    task automatic launch(input int f0, input int f1);
        wait_ready();
        features = {f1[3:0], f0[3:0]};
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        push_exp(f0, f1);
        features = 8'($urandom);
    endtask

    task automatic collect(input string tag);
        int d = 0;
        while (out_valid_v != '1 && d < 100) begin
            tick();
            d++;
        end
        chk({tag, "_latency"}, 32'(d), 32'd5);
        for (int k = 0; k < ND; k++) begin
            exp_pred_last[k]  = (q_pred.size() > 0) ? q_pred.pop_front() : -1;
            exp_score_last[k] = (q_score.size() > 0) ? q_score.pop_front() : -1;
            chk($sformatf("%s_pred%0d", tag, k), 32'(pred_v[k]), 32'(exp_pred_last[k]));
`ifdef BNN_SEQ_SCORE_EN
            chk($sformatf("%s_score%0d", tag, k), 32'(score_v[k]), 32'(exp_score_last[k]));
`endif
        end
    endtask

    initial begin
        int bad;

        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_in_ready", 32'(in_ready_v), 32'hF);
        chk("rst_out_valid", 32'(out_valid_v), 32'h0);
        for (int k = 0; k < ND; k++) begin
            chk($sformatf("rst_pred%0d", k), 32'(pred_v[k]), 32'd0);
`ifdef BNN_SEQ_SCORE_EN
            chk($sformatf("rst_score%0d", k), 32'(score_v[k]), 32'd0);
`endif
        end

        out_ready = 1'b1;
        launch(3, 0);
        collect("sign_neg");
        chk("sign_neg_hidden0000", 32'(pred_v[0]), 32'd0);
        chk("argmax_pred", 32'(pred_v[1]), 32'd1);
        chk("ties_pred", 32'(pred_v[2]), 32'd0);
        tick();
        launch(0, 0);
        collect("sign_zero");
        chk("sign_zero_hidden1111", 32'(pred_v[0]), 32'd1);
        tick();

        // Backpressure with a second request pending.
        out_ready = 1'b0;
        launch(5, 9);
        collect("bp");
        features = {4'd5, 4'd9};
        in_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid_v != '1 || in_ready_v != '0) bad++;
            for (int k = 0; k < ND; k++) begin
                if (32'(pred_v[k]) != 32'(exp_pred_last[k])) bad++;
`ifdef BNN_SEQ_SCORE_EN
                if (32'(score_v[k]) != 32'(exp_score_last[k])) bad++;
`endif
            end
        end
        chk("bp_hold_stable", 32'(bad), 32'd0);
        out_ready = 1'b1;
        tick();
        chk("bp_release_idle", 32'(in_ready_v), 32'hF);
        chk("bp_release_no_valid", 32'(out_valid_v), 32'h0);
        tick();
        in_valid = 1'b0;
        push_exp(9, 5);
        features = 8'($urandom);
        chk("bp_second_accepted", 32'(in_ready_v), 32'h0);
        collect("bp2");
        tick();

        // Reset during the second L1 cycle.
        wait_ready();
        features = {4'd6, 4'd1};
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_out_valid", 32'(out_valid_v), 32'h0);
        chk("midrst_in_ready", 32'(in_ready_v), 32'hF);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid_v != '0) bad++;
        end
        chk("midrst_discarded", 32'(bad), 32'd0);
        launch(7, 2);
        collect("post_rst");
        tick();

        // Back-to-back with in_valid and out_ready held high.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            int f0;
            int f1;
            f0 = (k % 2 == 0) ? 12 - k : k;
            f1 = (k % 2 == 0) ? k + 1 : 11 - k;
            features = {f1[3:0], f0[3:0]};
            wait_ready();
            tick();
            push_exp(f0, f1);
            features = 8'($urandom);
            collect($sformatf("b2b%0d", k));
        end
        in_valid = 1'b0;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
